// File: rtl/mem_access_stage.sv
// Y86-64 SEQ memory-access stage: issues at most one 64-bit load/store per
// instruction over a req/ack handshake and returns valM plus a status code.
module mem_access_stage #(
    parameter int unsigned MEM_SIZE = 8192,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] valM,
    output logic [3:0]  stat
);

    localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [63:0]   MAX_ADDR = 64'(MEM_SIZE - 8);
    localparam logic [3:0]    S_AOK    = 4'd1;
    localparam logic [3:0]    S_ADR    = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [63:0]   mem_addr_q;
    logic [63:0]   mem_wdata_q;
    logic          out_valid_q;
    logic [63:0]   valM_q;
    logic [3:0]    stat_q;

    logic          acc_d;
    logic          we_d;
    logic [63:0]   addr_d;
    logic [63:0]   wdata_d;

    always_comb begin
        acc_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = valE;
        wdata_d = valA;
        unique case (icode)
            4'h4, 4'hA: begin
                acc_d = 1'b1;
                we_d  = 1'b1;
            end
            4'h8: begin
                acc_d   = 1'b1;
                we_d    = 1'b1;
                wdata_d = valP;
            end
            4'h5: acc_d = 1'b1;
            4'h9, 4'hB: begin
                acc_d  = 1'b1;
                addr_d = valA;
            end
            default: acc_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            out_valid_q <= 1'b0;
            valM_q      <= '0;
            stat_q      <= S_AOK;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        cnt_q  <= '0;
                        valM_q <= '0;
                        if (!acc_d) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            stat_q      <= S_AOK;
                        end else if (addr_d > MAX_ADDR) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            stat_q      <= S_ADR;
                        end else begin
                            state_q     <= ACCESS;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= we_d;
                            mem_addr_q  <= addr_d;
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state_q     <= DONE;
                        mem_req_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        stat_q      <= mem_err ? S_ADR : S_AOK;
                        valM_q      <= (mem_err || mem_we_q) ? '0 : mem_rdata;
                    end else if (cnt_q == CNT_LAST) begin
                        // memory never answered: abort as an address fault
                        state_q     <= DONE;
                        mem_req_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        stat_q      <= S_ADR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        cnt_q       <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign out_valid = out_valid_q;
    assign valM      = valM_q;
    assign stat      = stat_q;

endmodule
